seq_serializer: RTL
===================

Name: seq_serializer

Overview:
- Parallel-to-serial feeder that sits directly upstream of the "1001" sequence detector and drives its X input.
- Accepts WIDTH-bit words over a valid/ready handshake.
- Buffers one word while another shifts, then emits bits MSB-first, one per CLK.
- Downstream can stall shifting via SER_EN; a pulse marks the end of each word.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- CNT_W, 5, width of the internal bit counter; must satisfy 2^CNT_W >= WIDTH.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  reset, synchronous, active-high.
- DIN  input  WIDTH  parallel word; bit WIDTH-1 is transmitted first.
- DIN_VALID  input  1  DIN holds a word to accept.
- DIN_READY  output  1  hold buffer can take a word; forced 0 while RST=1.
- SER_EN  input  1  downstream enable; 0 freezes the shifter.
- X  output  1  serial bit; 0 when X_VALID=0.
- X_VALID  output  1  X carries a payload bit this cycle.
- WORD_DONE  output  1  one-cycle pulse after a word's last bit is consumed.
- BUSY  output  1  shifter active or hold buffer full.

Behaviour:
- State: shift register SR[WIDTH-1:0], bit counter CNT, hold buffer HB[WIDTH-1:0] with flag HB_FULL, FSM {IDLE, SHIFT}.
- Reset (RST=1 at posedge), overriding everything, including a word mid-shift:
  - FSM=IDLE, SR=0, CNT=0, HB=0, HB_FULL=0.
  - X=0, X_VALID=0, WORD_DONE=0.
  - BUSY=0; DIN_READY=1 on the first cycle after RST deasserts.
- Handshake:
  - DIN_READY = ~HB_FULL & ~RST.
  - A transfer occurs at a posedge with DIN_VALID & DIN_READY; DIN is written to HB and HB_FULL is set.
  - DIN is ignored when DIN_READY=0; the upstream holds the word until ready.
- IDLE:
  - X_VALID=0, X=0.
  - If HB_FULL at a posedge: SR<=HB, HB_FULL<=0, CNT<=0, go to SHIFT.
  - Latency: a word accepted at edge k shows its MSB on X after edge k+1.
- SHIFT:
  - X_VALID=1, X=SR[WIDTH-1].
  - Posedge with SER_EN=1 and CNT<WIDTH-1: SR<=SR<<1, CNT<=CNT+1.
  - Posedge with SER_EN=1 and CNT=WIDTH-1 (last bit), WORD_DONE<=1 for one cycle, and:
    - if HB_FULL: SR<=HB, HB_FULL<=0, CNT<=0, stay in SHIFT, so the next word follows with no gap and X_VALID stays 1;
    - else: go to IDLE.
  - Posedge with SER_EN=0: SR, CNT, FSM, X and X_VALID all hold; WORD_DONE=0.
- Simultaneous events:
  - An accept cannot coincide with HB being drained in the same cycle, because DIN_READY is low while HB_FULL=1.
  - HB frees on the drain edge and can accept on the next edge; sustained throughput is 1 bit/cycle for WIDTH>=2.
- SER_EN in IDLE has no effect; a stall on the last bit delays WORD_DONE and the reload.
- BUSY = (FSM==SHIFT) | HB_FULL.
- X, X_VALID and WORD_DONE are driven from registers or register-only decode; there is no combinational path from DIN or DIN_VALID to them.

Test Plan:
1. Reset, then DIN=8'h93 with DIN_VALID for one cycle -> X_VALID rises one cycle after the accept. X = 1,0,0,1,0,0,1,1 over 8 cycles. WORD_DONE pulses once. Returns to IDLE and BUSY=0.
2. DIN=8'h93 then 8'h24 presented back-to-back, DIN_VALID held -> 16 contiguous X_VALID=1 cycles: 1001_0011_0010_0100. DIN_READY low while HB full. WORD_DONE pulses twice, 8 cycles apart.
3. SER_EN=0 for 3 cycles while bit index 3 of 8'hA5 is on X -> X holds 0 for those 3 cycles. Remaining bits 0,1,0,1 follow unchanged. WORD_DONE is delayed by 3 cycles.
4. HB full and shifter busy, DIN_VALID=1 with DIN=8'hFF -> DIN_READY=0 and the word is not accepted. It is accepted on the edge after the current word's last bit.
5. RST asserted at bit index 4 of 8'h93 with 8'h24 in HB -> after that edge X=0, X_VALID=0, BUSY=0, WORD_DONE=0. DIN_READY is 0 during RST and 1 after. 8'h24 is discarded.
6. Drive the 1001 sequence detector's X with 8'h93 then 8'h24 -> the detector sees the bitstream 1001_0011_0010_0100 with no idle gaps.

Source files
------------

// File: rtl/seq_serializer.sv
// Parallel-to-serial feeder for the 1001 detector: one-word hold buffer in front of
// an MSB-first shifter with downstream stall and an end-of-word pulse.
module seq_serializer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    input  logic             SER_EN,
    output logic             X,
    output logic             X_VALID,
    output logic             WORD_DONE,
    output logic             BUSY
);

    typedef enum logic [0:0] {IDLE, SHIFT} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] hb;
    logic             hb_full;
    logic [CNT_W-1:0] cnt;
    logic             word_done;

    logic last_bit;
    logic drain;
    logic accept;

    always_comb begin
        last_bit = (state == SHIFT) && SER_EN && (cnt == LAST_CNT);
        drain    = hb_full && ((state == IDLE) || last_bit);
        // Accept never overlaps a drain: both need opposite values of hb_full.
        accept   = DIN_VALID && !hb_full;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            hb        <= '0;
            hb_full   <= 1'b0;
            word_done <= 1'b0;
        end else begin
            word_done <= last_bit;
            case (state)
                IDLE: begin
                    if (hb_full) begin
                        sr    <= hb;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (SER_EN) begin
                        if (cnt == LAST_CNT) begin
                            if (hb_full) begin
                                sr  <= hb;
                                cnt <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            sr  <= sr << 1;
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                hb      <= DIN;
                hb_full <= 1'b1;
            end else if (drain) begin
                hb_full <= 1'b0;
            end
        end
    end

    always_comb begin
        DIN_READY = !hb_full && !RST;
        X_VALID   = (state == SHIFT);
        X         = (state == SHIFT) && sr[WIDTH-1];
        WORD_DONE = word_done;
        BUSY      = (state == SHIFT) || hb_full;
    end

endmodule
